// File: rtl/sm_pkg.sv
// rtl/sm_pkg.sv - shared types, op encodings and field helpers for sign-magnitude blocks
package sm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } sm_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Words are passed zero-extended to 64 bits; n is the magnitude width.
  function automatic logic sm_sign(input logic [63:0] word, input int n);
    return word[n[5:0]];
  endfunction

  function automatic logic [63:0] sm_mag(input logic [63:0] word, input int n);
    return word & ((64'd1 << n) - 64'd1);
  endfunction

endpackage

// File: rtl/sm_mag_compare.sv
// rtl/sm_mag_compare.sv - combinational unsigned magnitude compare
module sm_mag_compare #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_gt,
  output logic         o_eq
);

  assign o_gt = (i_a > i_b);
  assign o_eq = (i_a == i_b);

endmodule

// File: rtl/sm_serial_addsub.sv
// rtl/sm_serial_addsub.sv - bit-serial sign-magnitude adder/subtractor, one magnitude bit per clock
module sm_serial_addsub
  import sm_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [N:0]   a,
  input  logic [N:0]   b,
  output logic         busy,
  output logic         done,
  output logic [N:0]   sum,
  output logic         ovflw
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  sm_state_t     r_state;
  sm_state_t     w_state_next;
  logic [N-1:0]  r_x;
  logic [N-1:0]  r_y;
  logic [N-1:0]  r_res;
  logic          r_c;
  logic          r_eff_sub;
  logic          r_sign;
  logic [CW-1:0] r_cnt;
  logic [N:0]    r_sum;
  logic          r_ovflw;

  logic [N-1:0]  w_mag_a;
  logic [N-1:0]  w_mag_b;
  logic [N-1:0]  w_big;
  logic [N-1:0]  w_small;
  logic [N-1:0]  w_res_next;
  logic          w_gt;
  logic          w_eq;
  logic          w_a_big;
  logic          w_sb_eff;
  logic          w_eff_sub;
  logic          w_s;
  logic          w_c_next;
  logic          w_last;
  logic          w_load;

  assign w_mag_a   = N'(sm_mag(64'(a), N));
  assign w_mag_b   = N'(sm_mag(64'(b), N));
  assign w_sb_eff  = sm_sign(64'(b), N) ^ (op == OP_SUB);
  assign w_eff_sub = sm_sign(64'(a), N) ^ w_sb_eff;

  sm_mag_compare #(.N(N)) u_cmp (
    .i_a  (w_mag_a),
    .i_b  (w_mag_b),
    .o_gt (w_gt),
    .o_eq (w_eq)
  );

  assign w_a_big = w_gt | w_eq;
  assign w_big   = w_a_big ? w_mag_a : w_mag_b;
  assign w_small = w_a_big ? w_mag_b : w_mag_a;

  // Larger minus smaller is done as big + ~small + 1, so the result is never negative.
  assign w_s        = r_x[0] ^ r_y[0] ^ r_c;
  assign w_c_next   = (r_x[0] & r_y[0]) | (r_x[0] & r_c) | (r_y[0] & r_c);
  assign w_res_next = {w_s, r_res[N-1:1]};
  assign w_last     = (r_cnt == LAST);

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = ADD;
          w_load       = 1'b1;
        end
      end
      ADD:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_res     <= '0;
      r_c       <= 1'b0;
      r_eff_sub <= 1'b0;
      r_sign    <= 1'b0;
      r_cnt     <= '0;
      r_sum     <= '0;
      r_ovflw   <= 1'b0;
    end else if (w_load) begin
      r_x       <= w_big;
      r_y       <= w_eff_sub ? ~w_small : w_small;
      r_c       <= w_eff_sub;
      r_eff_sub <= w_eff_sub;
      r_sign    <= w_a_big ? sm_sign(64'(a), N) : w_sb_eff;
      r_res     <= '0;
      r_cnt     <= '0;
    end else if (r_state == ADD) begin
      r_x   <= r_x >> 1;
      r_y   <= r_y >> 1;
      r_c   <= w_c_next;
      r_res <= w_res_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        // A zero magnitude always carries a positive sign.
        r_sum   <= {(w_res_next != '0) & r_sign, w_res_next};
        r_ovflw <= w_c_next & ~r_eff_sub;
      end
    end
  end

  assign busy  = (r_state != IDLE);
  assign done  = (r_state == DONE);
  assign sum   = r_sum;
  assign ovflw = r_ovflw;

endmodule
